// File: rtl/spi_host_tx_if.sv
// Command/data handshake and serial pin bundle between the SPI host transmitter and its user.
// The master side issues commands and data bytes; the slave side is the transmitter.
interface spi_host_tx_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_addr;
    logic [5:0] cmd_len;
    logic       cmd_irst;
    logic       data_valid;
    logic       data_ready;
    logic [7:0] data_in;
    logic       busy;
    logic       done;
    logic       sclk;
    logic       iclk;
    logic       sdo;

    modport master (
        output cmd_valid, cmd_addr, cmd_len, cmd_irst, data_valid, data_in,
        input  cmd_ready, data_ready, busy, done, sclk, iclk, sdo
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, cmd_irst, data_valid, data_in,
        output cmd_ready, data_ready, busy, done, sclk, iclk, sdo
    );
endinterface

// File: rtl/spi_host_tx.sv
// SPI host transmitter: optional iclk reset burst, then address and cmd_len data bytes MSB first.
// Pins change the cycle after accept; a missing data byte parks the bus in FETCH with sclk low.
module spi_host_tx #(
    parameter int CLK_DIV     = 2,
    parameter int IRST_PULSES = 8
) (
    input  logic         clk,
    input  logic         rstn,
    spi_host_tx_if.slave bus
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PUL_W = (IRST_PULSES > 1) ? $clog2(IRST_PULSES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_IRST_HI, S_IRST_LO, S_SHIFT_LO, S_SHIFT_HI, S_FETCH, S_DONE
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [DIV_W-1:0]   r_div,   w_div_nxt;
    logic [PUL_W-1:0]   r_pulse, w_pulse_nxt;
    logic [2:0]         r_bit,   w_bit_nxt;
    logic [5:0]         r_bytes, w_bytes_nxt;
    logic [7:0]         r_shreg, w_shreg_nxt;
    logic               r_sclk,  w_sclk_nxt;
    logic               r_iclk,  w_iclk_nxt;
    logic               r_sdo,   w_sdo_nxt;
    logic               w_tick;
    logic               w_timed;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_pulse <= '0;
            r_bit   <= '0;
            r_bytes <= '0;
            r_shreg <= '0;
            r_sclk  <= 1'b0;
            r_iclk  <= 1'b0;
            r_sdo   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_pulse <= w_pulse_nxt;
            r_bit   <= w_bit_nxt;
            r_bytes <= w_bytes_nxt;
            r_shreg <= w_shreg_nxt;
            r_sclk  <= w_sclk_nxt;
            r_iclk  <= w_iclk_nxt;
            r_sdo   <= w_sdo_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = '0;
        w_pulse_nxt = r_pulse;
        w_bit_nxt   = r_bit;
        w_bytes_nxt = r_bytes;
        w_shreg_nxt = r_shreg;
        w_tick      = (r_div == DIV_W'(CLK_DIV - 1));
        w_timed     = (r_state == S_IRST_HI) || (r_state == S_IRST_LO) ||
                      (r_state == S_SHIFT_LO) || (r_state == S_SHIFT_HI);

        if (w_timed && !w_tick) begin
            w_div_nxt = r_div + DIV_W'(1);
        end

        unique case (r_state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    // Address is preloaded now so the reset burst can hand straight to shifting.
                    w_shreg_nxt = bus.cmd_addr;
                    w_bytes_nxt = bus.cmd_len;
                    w_pulse_nxt = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = bus.cmd_irst ? S_IRST_HI : S_SHIFT_LO;
                end
            end
            S_IRST_HI: begin
                if (w_tick) w_state_nxt = S_IRST_LO;
            end
            S_IRST_LO: begin
                if (w_tick) begin
                    if (r_pulse == PUL_W'(IRST_PULSES - 1)) begin
                        w_state_nxt = S_SHIFT_LO;
                    end else begin
                        w_pulse_nxt = r_pulse + PUL_W'(1);
                        w_state_nxt = S_IRST_HI;
                    end
                end
            end
            S_SHIFT_LO: begin
                if (w_tick) w_state_nxt = S_SHIFT_HI;
            end
            S_SHIFT_HI: begin
                if (w_tick) begin
                    w_shreg_nxt = {r_shreg[6:0], 1'b0};
                    w_bit_nxt   = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = (r_bytes == 6'd0) ? S_DONE : S_FETCH;
                    end else begin
                        w_state_nxt = S_SHIFT_LO;
                    end
                end
            end
            S_FETCH: begin
                if (bus.data_valid) begin
                    w_shreg_nxt = bus.data_in;
                    w_bytes_nxt = r_bytes - 6'd1;
                    w_bit_nxt   = '0;
                    w_state_nxt = S_SHIFT_LO;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Pins are registered from the next state, so sdo only moves on the edge sclk is low after.
        w_sclk_nxt = (w_state_nxt == S_SHIFT_HI);
        w_iclk_nxt = (w_state_nxt == S_IRST_HI);
        w_sdo_nxt  = (w_state_nxt == S_SHIFT_LO) ? w_shreg_nxt[7] : r_sdo;
    end

    assign bus.cmd_ready  = (r_state == S_IDLE);
    assign bus.data_ready = (r_state == S_FETCH);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = (r_state == S_DONE);
    assign bus.sclk       = r_sclk;
    assign bus.iclk       = r_iclk;
    assign bus.sdo        = r_sdo;
endmodule

// File: tb/tb_spi_host_tx.sv
// Scoreboard bench for spi_host_tx: a frame model predicts the bit stream, pulse counts and frame length.
module tb_spi_host_tx;
    localparam int D = 2;
    localparam int P = 8;
    localparam int LIMIT = 5000;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    spi_host_tx_if bus();
    spi_host_tx #(.CLK_DIV(D), .IRST_PULSES(P)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    typedef struct { bit irst; int len; int stall; } frame_t;
    typedef struct { logic [7:0] d; int stall; } dbyte_t;

    int     checks = 0;
    int     failures = 0;
    frame_t exp_frames[$];
    bit     exp_bits[$];
    int     exp_stalls[$];
    dbyte_t data_q[$];
    logic [7:0] cur_data[64];
    int     cur_stall[64];
    bit     hs_pending = 1'b0;
    bit     stall_started = 1'b0;
    int     stall_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: a frame is the address then each data byte, MSB first.
    task automatic push_frame(input logic [7:0] addr, input int len, input bit irst);
        frame_t f;
        f.irst = irst; f.len = len; f.stall = 0;
        for (int b = 7; b >= 0; b--) exp_bits.push_back(addr[b]);
        for (int i = 0; i < len; i++) begin
            dbyte_t e;
            e.d = cur_data[i]; e.stall = cur_stall[i];
            data_q.push_back(e);
            exp_stalls.push_back(cur_stall[i]);
            f.stall += cur_stall[i];
            for (int b = 7; b >= 0; b--) exp_bits.push_back(cur_data[i][b]);
        end
        exp_frames.push_back(f);
    endtask

    task automatic drive_cmd(input logic [7:0] addr, input int len, input bit irst, input bit hold);
        int n;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_addr = addr; bus.cmd_len = 6'(len); bus.cmd_irst = irst;
        n = 0;
        while (!bus.cmd_ready && n < LIMIT) begin @(negedge clk); n++; end
        check("accept_wait", int'(n < LIMIT), 1);
        @(negedge clk);
        check("busy_after_accept", int'(bus.busy), 1);
        check("iclk_after_accept", int'(bus.iclk), int'(irst));
        check("sclk_after_accept", int'(bus.sclk), 0);
        if (!irst) check("sdo_after_accept", int'(bus.sdo), int'(addr[7]));
        if (!hold) bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!bus.done && n < LIMIT) begin @(negedge clk); n++; end
        check("done_wait", int'(n < LIMIT), 1);
    endtask

    task automatic clear_data(input int len);
        for (int i = 0; i < 64; i++) begin
            cur_data[i] = 8'($urandom_range(0, 255));
            cur_stall[i] = 0;
        end
        if (len < 0) cur_stall[0] = 0;
    endtask

    // Data source: a byte's stall counts only while the transmitter is waiting in FETCH.
    initial begin
        bus.data_valid = 1'b0; bus.data_in = 8'h00;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                hs_pending = 1'b0; stall_started = 1'b0; bus.data_valid = 1'b0;
            end else begin
                if (hs_pending) begin
                    void'(data_q.pop_front());
                    hs_pending = 1'b0; stall_started = 1'b0;
                end
                if (data_q.size() > 0) begin
                    if (!stall_started) begin stall_cnt = data_q[0].stall; stall_started = 1'b1; end
                    if (stall_cnt > 0) begin
                        bus.data_valid = 1'b0;
                        if (bus.data_ready) stall_cnt--;
                    end else begin
                        bus.data_valid = 1'b1; bus.data_in = data_q[0].d;
                    end
                end else begin
                    bus.data_valid = 1'b0;
                end
                hs_pending = bus.data_valid && bus.data_ready;
            end
        end
    end

    // Monitor: compares pin activity against the scoreboard queues.
    initial begin
        bit p_sclk, p_iclk, p_sdo, p_dr, eb;
        int sclk_run, iclk_run, fetch_run, sdo_stable, rises, irises, busy_cnt;
        frame_t f;
        p_sclk = 0; p_iclk = 0; p_sdo = 0; p_dr = 0;
        sclk_run = 0; iclk_run = 0; fetch_run = 0; sdo_stable = 0; rises = 0; irises = 0; busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                p_sclk = 0; p_iclk = 0; p_sdo = 0; p_dr = 0;
                sclk_run = 0; iclk_run = 0; fetch_run = 0; sdo_stable = 0;
                rises = 0; irises = 0; busy_cnt = 0;
                continue;
            end
            check("cmd_ready_vs_busy", int'(bus.cmd_ready), int'(!bus.busy));
            if (bus.busy) check("sclk_iclk_overlap", int'(bus.sclk && bus.iclk), 0);
            if (bus.sdo !== p_sdo) check("sdo_moved_sclk_high", int'(bus.sclk), 0);
            if (bus.sclk && !p_sclk) begin
                rises++;
                check("sdo_setup", int'(sdo_stable >= D), 1);
                check("bit_expected_at_rise", int'(exp_bits.size() > 0), 1);
                if (exp_bits.size() > 0) begin
                    eb = exp_bits.pop_front();
                    check("sdo_bit", int'(bus.sdo), int'(eb));
                end
            end
            if (!bus.sclk && p_sclk) check("sclk_high_width", sclk_run, D);
            if (bus.iclk && !p_iclk) irises++;
            if (!bus.iclk && p_iclk) check("iclk_high_width", iclk_run, D);
            if (!bus.data_ready && p_dr) begin
                check("fetch_expected", int'(exp_stalls.size() > 0), 1);
                if (exp_stalls.size() > 0) check("fetch_cycles", fetch_run, exp_stalls.pop_front() + 1);
            end
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                check("done_expected", int'(exp_frames.size() > 0), 1);
                if (exp_frames.size() > 0) begin
                    f = exp_frames.pop_front();
                    check("sclk_rises", rises, 8 * (f.len + 1));
                    check("iclk_pulses", irises, f.irst ? P : 0);
                    check("busy_cycles", busy_cnt,
                          (2 * P * int'(f.irst) + 16 * (f.len + 1)) * D + f.len + 1 + f.stall);
                end
                rises = 0; irises = 0; busy_cnt = 0;
            end
            sdo_stable = (bus.sdo !== p_sdo) ? 1 : sdo_stable + 1;
            sclk_run   = bus.sclk ? sclk_run + 1 : 0;
            iclk_run   = bus.iclk ? iclk_run + 1 : 0;
            fetch_run  = bus.data_ready ? fetch_run + 1 : 0;
            p_sclk = bus.sclk; p_iclk = bus.iclk; p_sdo = bus.sdo; p_dr = bus.data_ready;
        end
    end

    initial begin
        int n, k, len;
        bit lp, irst;
        bus.cmd_valid = 1'b0; bus.cmd_addr = 8'h00; bus.cmd_len = 6'd0; bus.cmd_irst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", int'(bus.cmd_ready), 1);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_data_ready", int'(bus.data_ready), 0);
        check("rst_pins", int'({bus.sclk, bus.iclk, bus.sdo}), 0);
        #2 rstn = 1'b1;

        // Three-byte write without reset burst.
        clear_data(0);
        cur_data[0] = 8'h10; cur_data[1] = 8'h02; cur_data[2] = 8'h01;
        push_frame(8'h01, 3, 1'b0); drive_cmd(8'h01, 3, 1'b0, 1'b0); wait_done();

        // Reset burst followed by an address-only frame.
        clear_data(0);
        push_frame(8'h04, 0, 1'b1); drive_cmd(8'h04, 0, 1'b1, 1'b0); wait_done();

        // Second data byte withheld for 10 cycles.
        clear_data(0);
        cur_stall[1] = 10;
        push_frame(8'h3C, 2, 1'b0); drive_cmd(8'h3C, 2, 1'b0, 1'b0); wait_done();

        // cmd_valid held through a frame: the next accept lands right after done.
        clear_data(0);
        push_frame(8'h55, 1, 1'b0);
        push_frame(8'h55, 1, 1'b0);
        drive_cmd(8'h55, 1, 1'b0, 1'b1);
        wait_done();
        @(negedge clk);
        check("ready_after_done", int'(bus.cmd_ready), 1);
        @(negedge clk);
        check("second_accept_busy", int'(bus.busy), 1);
        check("second_accept_ready", int'(bus.cmd_ready), 0);
        bus.cmd_valid = 1'b0;
        wait_done();

        // Asynchronous abort while bit 3 of the address is high on sclk.
        clear_data(0);
        push_frame(8'hFF, 2, 1'b0); drive_cmd(8'hFF, 2, 1'b0, 1'b0);
        n = 0; k = 0; lp = bus.sclk;
        while (k < 4 && n < LIMIT) begin
            @(negedge clk); n++;
            if (bus.sclk && !lp) k++;
            lp = bus.sclk;
        end
        check("abort_reach_bit3", int'(k), 4);
        check("abort_sdo_before", int'(bus.sdo), 1);
        #2 rstn = 1'b0;
        #1;
        check("abort_pins", int'({bus.sclk, bus.iclk, bus.sdo}), 0);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        exp_bits.delete(); exp_frames.delete(); exp_stalls.delete(); data_q.delete();
        repeat (2) @(negedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
        check("abort_ready_after", int'(bus.cmd_ready), 1);
        check("abort_no_done", int'(bus.done), 0);

        // Longest frame, data always available.
        clear_data(0);
        push_frame(8'hA7, 63, 1'b0); drive_cmd(8'hA7, 63, 1'b0, 1'b0); wait_done();

        // Randomized frames.
        for (int t = 0; t < 15; t++) begin
            len  = $urandom_range(0, 6);
            irst = 1'($urandom_range(0, 1));
            clear_data(0);
            for (int i = 0; i < len; i++)
                if ($urandom_range(0, 3) == 0) cur_stall[i] = $urandom_range(1, 8);
            n = $urandom_range(0, 255);
            push_frame(8'(n), len, irst); drive_cmd(8'(n), len, irst, 1'b0); wait_done();
        end

        repeat (5) @(negedge clk);
        check("bits_left", exp_bits.size(), 0);
        check("frames_left", exp_frames.size(), 0);
        check("fetches_left", exp_stalls.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
